// File: rtl/pixel_plot_writer.sv
// Pixel plot writer: queues plotted pixels in a small FIFO, drops off-screen
// pixels and issues one frame-buffer write per on-screen pixel (y*WIDTH + x).
module pixel_plot_writer #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int DEPTH  = 4
) (
   input  logic        clkf,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [10:0] in_x,
   input  logic [10:0] in_y,
   input  logic        in_color,
   output logic        in_ready,
   output logic        mem_wr,
   output logic [18:0] mem_addr,
   output logic        mem_data,
   input  logic        mem_ready,
   output logic        busy,
   output logic [15:0] wr_count,
   output logic [15:0] clip_count
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
   localparam logic [10:0] LP_W    = 11'(WIDTH);
   localparam logic [10:0] LP_H    = 11'(HEIGHT);
   localparam logic [18:0] LP_W19  = 19'(WIDTH);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [22:0]     r_fifo [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [18:0]     r_addr;
   logic            r_data;
   logic [15:0]     r_wr_count;
   logic [15:0]     r_clip_count;

   logic            w_push;
   logic            w_pop;
   logic            w_nonempty;
   logic            w_done;
   logic            w_on_screen;
   logic [22:0]     w_head;
   logic [10:0]     w_head_x;
   logic [10:0]     w_head_y;
   logic            w_head_c;
   logic [18:0]     w_addr;

   assign in_ready    = (r_count < LP_DEPTH);
   assign w_nonempty  = (r_count != {CW{1'b0}});
   assign w_push      = in_valid & in_ready;
   assign w_done      = (r_state == ST_WRITE) & mem_ready;
   assign w_pop       = w_nonempty & ((r_state == ST_IDLE) | mem_ready);
   assign w_head      = r_fifo[r_rd_ptr];
   assign w_head_x    = w_head[10:0];
   assign w_head_y    = w_head[21:11];
   assign w_head_c    = w_head[22];
   assign w_on_screen = (w_head_x < LP_W) & (w_head_y < LP_H);
   // Only in-range coordinates reach the frame buffer, so 19 bits never overflow.
   assign w_addr      = ({8'd0, w_head_y} * LP_W19) + {8'd0, w_head_x};

   assign mem_wr     = (r_state == ST_WRITE);
   assign mem_addr   = r_addr;
   assign mem_data   = r_data;
   assign busy       = w_nonempty | mem_wr;
   assign wr_count   = r_wr_count;
   assign clip_count = r_clip_count;

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clkf) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= {in_color, in_y, in_x};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clkf) begin
      if (!reset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Output-stage state register.
   always_ff @(posedge clkf) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: a popped on-screen head always lands in WRITE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pop && w_on_screen) begin
               w_state_nxt = ST_WRITE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (!mem_ready) begin
               w_state_nxt = ST_WRITE;
            end else if (w_pop && w_on_screen) begin
               w_state_nxt = ST_WRITE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Write address/data: loaded only on an on-screen pop, otherwise held.
   always_ff @(posedge clkf) begin
      if (!reset) begin
         r_addr <= 19'd0;
         r_data <= 1'b0;
      end else if (w_pop && w_on_screen) begin
         r_addr <= w_addr;
         r_data <= w_head_c;
      end else begin
         r_addr <= r_addr;
         r_data <= r_data;
      end
   end

   // Saturating write and clip counters.
   always_ff @(posedge clkf) begin
      if (!reset) begin
         r_wr_count   <= 16'd0;
         r_clip_count <= 16'd0;
      end else begin
         if (w_done && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
         if (w_pop && !w_on_screen && (r_clip_count != 16'hFFFF)) begin
            r_clip_count <= r_clip_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pixel_plot_writer.sv
// Randomized and directed bench for pixel_plot_writer against a queue-based
// transaction model of the pixel pipeline.
module tb_pixel_plot_writer;

   localparam int W = 640;
   localparam int H = 480;
   localparam int D = 4;

   logic        clkf = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [10:0] in_x;
   logic [10:0] in_y;
   logic        in_color;
   logic        in_ready;
   logic        mem_wr;
   logic [18:0] mem_addr;
   logic        mem_data;
   logic        mem_ready;
   logic        busy;
   logic [15:0] wr_count;
   logic [15:0] clip_count;

   always #5 clkf = ~clkf;

   pixel_plot_writer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
      .clkf      (clkf),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_color  (in_color),
      .in_ready  (in_ready),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .busy      (busy),
      .wr_count  (wr_count),
      .clip_count(clip_count)
   );

   typedef struct {
      int x;
      int y;
      bit c;
   } pix_t;

   // Reference model: pending pixels, one outstanding write, two counters.
   pix_t q[$];
   bit   m_wr;
   int   m_addr;
   bit   m_data;
   int   m_wrc;
   int   m_clip;
   bit   m_rst_seen;

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
      end
   endtask

   task automatic model_edge();
      pix_t p;
      bit   acc;
      bit   can_pop;
      if (!reset) begin
         q.delete();
         m_wr = 1'b0; m_addr = 0; m_data = 1'b0; m_wrc = 0; m_clip = 0;
         m_rst_seen = 1'b1;
      end else begin
         m_rst_seen = 1'b0;
         acc     = in_valid && (q.size() < D);
         can_pop = (q.size() > 0) && (!m_wr || mem_ready);
         if (m_wr && mem_ready) begin
            if (m_wrc < 65535) m_wrc++;
            m_wr = 1'b0;
         end
         if (can_pop) begin
            p = q.pop_front();
            if (p.x < W && p.y < H) begin
               m_wr   = 1'b1;
               m_addr = p.y * W + p.x;
               m_data = p.c;
            end else begin
               if (m_clip < 65535) m_clip++;
            end
         end
         if (acc) begin
            p.x = int'(in_x); p.y = int'(in_y); p.c = in_color;
            q.push_back(p);
         end
      end
   endtask

   task automatic compare_all();
      check("in_ready",   32'(in_ready),   32'(q.size() < D));
      check("busy",       32'(busy),       32'((q.size() > 0) || m_wr));
      check("mem_wr",     32'(mem_wr),     32'(m_wr));
      if (m_wr || m_rst_seen) begin
         check("mem_addr", 32'(mem_addr), 32'(m_addr));
         check("mem_data", 32'(mem_data), 32'(m_data));
      end
      check("wr_count",   32'(wr_count),   32'(m_wrc));
      check("clip_count", 32'(clip_count), 32'(m_clip));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clkf);
      #1;
      compare_all();
   endtask

   task automatic drive(input bit v, input int x, input int y, input bit c);
      in_valid = v;
      in_x     = 11'(x);
      in_y     = 11'(y);
      in_color = c;
   endtask

   function automatic int pick_coord(input int lim);
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
         0:       return lim - 1;
         1:       return lim;
         2:       return 2047;
         3:       return 0;
         default: return int'($urandom_range(0, lim - 1));
      endcase
   endfunction

   // Pushes n pixels of a generated sequence, holding each until accepted.
   task automatic push_seq(input int n, input int kind, input int budget, output int accepted);
      int  k;
      bit  a;
      k = 0;
      accepted = 0;
      drive(1'b1, 0, 0, 1'b0);
      for (int t = 0; t < budget && k < n; t++) begin
         if (kind == 0) drive(1'b1, 100 + (k % 10), 50 + (k / 10), 1'(k));
         else           drive(1'b1, 20 + k, 30 + k, 1'(k + 1));
         a = in_ready;
         tick();
         if (a) begin
            k++;
            accepted++;
         end
      end
      drive(1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      int acc;
      reset     = 1'b0;
      mem_ready = 1'b0;
      drive(1'b1, 5, 5, 1'b1);
      q.delete();
      m_wr = 1'b0; m_addr = 0; m_data = 1'b0; m_wrc = 0; m_clip = 0; m_rst_seen = 1'b0;

      // Reset, with a pixel presented that must not be accepted.
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy",     32'(busy),     32'd0);
      reset = 1'b1;
      drive(1'b0, 0, 0, 1'b0);
      tick();

      // Single pixel (10,2,1).
      mem_ready = 1'b1;
      drive(1'b1, 10, 2, 1'b1);
      tick();
      drive(1'b0, 0, 0, 1'b0);
      tick();
      check("s1_mem_wr", 32'(mem_wr),   32'd1);
      check("s1_addr",   32'(mem_addr), 32'd1290);
      check("s1_data",   32'(mem_data), 32'd1);
      tick();
      check("s1_wr_idle", 32'(mem_wr),   32'd0);
      check("s1_wrc",     32'(wr_count), 32'd1);

      // Clipping: two off-screen, one at the far corner.
      drive(1'b1, 640, 0, 1'b1); tick();
      drive(1'b1, 0, 480, 1'b1); tick();
      drive(1'b1, 639, 479, 1'b1); tick();
      drive(1'b0, 0, 0, 1'b0); tick();
      check("clip_addr", 32'(mem_addr), 32'd307199);
      repeat (4) tick();
      check("clip_cnt", 32'(clip_count), 32'd2);
      check("clip_wrc", 32'(wr_count),   32'd2);

      // Back-pressure: 4 in FIFO + 1 held in the output stage.
      mem_ready = 1'b0;
      push_seq(6, 1, 8, acc);
      check("bp_accepted", 32'(acc), 32'd5);
      check("bp_ready",    32'(in_ready), 32'd0);
      mem_ready = 1'b1;
      repeat (8) tick();
      check("bp_wrc", 32'(wr_count), 32'd7);

      // Streaming 10x10 raster at (100,50).
      push_seq(100, 0, 200, acc);
      check("st_accepted", 32'(acc), 32'd100);
      repeat (4) tick();
      check("st_wrc",  32'(wr_count), 32'd107);
      check("st_busy", 32'(busy),     32'd0);

      // Reset mid-operation with writes stalled.
      mem_ready = 1'b0;
      push_seq(3, 1, 6, acc);
      check("mr_busy_pre", 32'(busy), 32'd1);
      reset = 1'b0;
      drive(1'b1, 1, 1, 1'b1);
      tick();
      reset = 1'b1;
      drive(1'b0, 0, 0, 1'b0);
      check("mr_mem_wr",   32'(mem_wr),     32'd0);
      check("mr_busy",     32'(busy),       32'd0);
      check("mr_ready",    32'(in_ready),   32'd1);
      check("mr_wrc",      32'(wr_count),   32'd0);
      check("mr_clip",     32'(clip_count), 32'd0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         drive(1'($urandom_range(0, 2) != 0), pick_coord(W), pick_coord(H), 1'($urandom_range(0, 1)));
         mem_ready = 1'($urandom_range(0, 3) != 0);
         reset     = 1'($urandom_range(0, 299) != 0);
         tick();
      end
      reset = 1'b1;

      // Saturation: more than 65535 back-to-back writes.
      reset = 1'b0; tick(); reset = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 65540; i++) begin
         drive(1'b1, i % W, 7, 1'(i));
         tick();
      end
      drive(1'b0, 0, 0, 1'b0);
      repeat (4) tick();
      check("sat_wrc", 32'(wr_count), 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
